// File: rtl/pixel_stream_feeder.sv
// Raster-order frame reader: synchronous-read frame RAM -> one pixel/cycle stream with stall skid buffer.
// Define FEEDER_FLUSH_EN to append HALF_WIN*IMG_W+HALF_WIN PAD_VALUE pixels after the image.
module pixel_stream_feeder #(
    parameter int unsigned      IMG_W     = 64,
    parameter int unsigned      IMG_H     = 64,
    parameter int unsigned      PIX_W     = 8,
    parameter int unsigned      ADDR_W    = 12,
    parameter int unsigned      HALF_WIN  = 3,
    parameter logic [PIX_W-1:0] PAD_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_rd_data,
    input  logic              stall,
    output logic              data_enable,
    output logic [PIX_W-1:0]  data_out,
    output logic              line_start,
    output logic              frame_last,
    output logic              busy,
    output logic              done
);
    localparam int unsigned IMG_PIX   = IMG_W * IMG_H;
    localparam int unsigned FLUSH_LEN = HALF_WIN * IMG_W + HALF_WIN;
`ifdef FEEDER_FLUSH_EN
    localparam int unsigned TOTAL     = IMG_PIX + FLUSH_LEN;
`else
    localparam int unsigned TOTAL     = IMG_PIX;
`endif
    localparam int unsigned LAST_ROW  = (TOTAL - 1) / IMG_W;
    localparam int unsigned LAST_COL  = (TOTAL - 1) % IMG_W;
    localparam int unsigned COL_W     = $clog2(IMG_W);
    localparam int unsigned ROW_W     = $clog2((IMG_PIX + FLUSH_LEN) / IMG_W + 2);
    localparam int unsigned CNT_W     = $clog2(IMG_PIX + 1);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

    state_t             state;
    logic               out_valid;
    logic               skid_valid;
    logic [PIX_W-1:0]   skid_data;
    logic               rd_valid;
    logic [CNT_W-1:0]   rd_cnt;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;

    logic [1:0]         occ_after;
    logic               col_wrap;
    logic               img_last;
    logic [COL_W-1:0]   col_nxt;
    logic [ROW_W-1:0]   row_nxt;

`ifndef FEEDER_FLUSH_EN
    logic unused_pad;
    assign unused_pad = ^PAD_VALUE;
`endif

    assign data_enable = out_valid & ~stall;

    // Occupancy counts buffered pixels plus the read whose data is on mem_rd_data now.
    always_comb begin
        occ_after = 2'(out_valid) + 2'(skid_valid) + 2'(rd_valid) - 2'(data_enable);
        col_wrap  = (col == COL_W'(IMG_W - 1));
        col_nxt   = col_wrap ? '0 : col + COL_W'(1);
        row_nxt   = col_wrap ? row + ROW_W'(1) : row;
        img_last  = col_wrap && (row == ROW_W'(IMG_H - 1));
        mem_rd_en = (state == STREAM) && (rd_cnt != CNT_W'(IMG_PIX)) && (occ_after < 2'd2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            rd_valid   <= 1'b0;
            data_out   <= '0;
            skid_data  <= '0;
            mem_addr   <= '0;
            rd_cnt     <= '0;
            col        <= '0;
            row        <= '0;
            line_start <= 1'b0;
            frame_last <= 1'b0;
        end else begin
            done     <= 1'b0;
            rd_valid <= mem_rd_en;
            if (mem_rd_en) begin
                mem_addr <= mem_addr + ADDR_W'(1);
                rd_cnt   <= rd_cnt + CNT_W'(1);
            end
            // Markers follow the transfer count, so they describe the next pixel presented.
            if (data_enable) begin
                col        <= col_nxt;
                row        <= row_nxt;
                line_start <= (col_nxt == '0) && (row_nxt < ROW_W'(IMG_H));
                frame_last <= (col_nxt == COL_W'(LAST_COL)) && (row_nxt == ROW_W'(LAST_ROW));
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= STREAM;
                        busy       <= 1'b1;
                        mem_addr   <= base_addr;
                        rd_cnt     <= '0;
                        col        <= '0;
                        row        <= '0;
                        line_start <= 1'b1;
                        frame_last <= 1'b0;
                    end
                end
                STREAM: begin
                    // Output register drains from skid first, then from the RAM, preserving order.
                    if (data_enable) begin
                        if (skid_valid) begin
                            data_out   <= skid_data;
                            skid_valid <= rd_valid;
                            skid_data  <= mem_rd_data;
                        end else if (rd_valid) begin
                            data_out <= mem_rd_data;
                        end else begin
                            out_valid <= 1'b0;
                        end
                    end else if (rd_valid) begin
                        if (out_valid) begin
                            skid_data  <= mem_rd_data;
                            skid_valid <= 1'b1;
                        end else begin
                            data_out  <= mem_rd_data;
                            out_valid <= 1'b1;
                        end
                    end
                    if (data_enable && img_last) begin
`ifdef FEEDER_FLUSH_EN
                        state     <= FLUSH;
                        data_out  <= PAD_VALUE;
                        out_valid <= 1'b1;
`else
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        out_valid <= 1'b0;
`endif
                    end
                end
`ifdef FEEDER_FLUSH_EN
                FLUSH: begin
                    if (data_enable) begin
                        if (frame_last) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            out_valid <= 1'b0;
                        end else begin
                            data_out <= PAD_VALUE;
                        end
                    end
                end
`endif
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
